// File: rtl/dcache_miss_controller.sv
// dcache_miss_controller: stalls the MEM stage on load misses and stores, fetching lines and
// forwarding write-through stores over a single-outstanding req/ready memory handshake.
module dcache_miss_controller #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cache_hit,
    output logic              stall,
    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              fill_en,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              inv_en,
    output logic              busy,
    output logic [CNT_W-1:0]  miss_count
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, FILL, WR_WAIT, WR_DONE} state_t;
    state_t state;
    logic wrHit;
    logic loadMiss;
    assign loadMiss = cpu_read & ~cache_hit;
    // WR_DONE is the one busy state that lets the pipeline advance past the store
    assign stall = (state == IDLE) ? (cpu_write | loadMiss) : (state != WR_DONE);
    assign busy  = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wrHit         <= 1'b0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            fill_en       <= 1'b0;
            fill_addr     <= '0;
            fill_data     <= '0;
            inv_en        <= 1'b0;
            miss_count    <= '0;
        end else begin
            fill_en <= 1'b0;
            inv_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        mem_addr      <= cpu_addr;
                        mem_wdata     <= cpu_wdata;
                        mem_write_req <= 1'b1;
                        wrHit         <= cache_hit;
                        state         <= WR_WAIT;
                    end else if (loadMiss) begin
                        mem_addr     <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_read_req <= 1'b1;
                        miss_count   <= (&miss_count) ? miss_count : miss_count + 1'b1;
                        state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        fill_data    <= mem_rdata;
                        fill_addr    <= mem_addr;
                        mem_read_req <= 1'b0;
                        fill_en      <= 1'b1;
                        state        <= FILL;
                    end
                end
                FILL: state <= IDLE;
                WR_WAIT: begin
                    if (mem_ready) begin
                        mem_write_req <= 1'b0;
                        state         <= WR_DONE;
                        if (wrHit) begin
                            inv_en    <= 1'b1;
                            fill_addr <= {mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                WR_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_miss_controller.sv
// tb_dcache_miss_controller: directed stimulus with queued expectations checked by a monitor;
// a narrow-counter instance exercises miss_count saturation.
module tb_dcache_miss_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpuRead = 1'b0, cpuWrite = 1'b0, cacheHit = 1'b0, memReady = 1'b0;
    logic [31:0] cpuAddr = '0, cpuWdata = '0;
    logic [127:0] memRdata = '0;
    logic stall, memReadReq, memWriteReq, fillEn, invEn, busy;
    logic [31:0] memAddr, memWdata, fillAddr;
    logic [127:0] fillData;
    logic [15:0] missCount;
    logic sStall, sReadReq, sWriteReq, sFillEn, sInvEn, sBusy;
    logic [31:0] sMemAddr, sMemWdata, sFillAddr;
    logic [127:0] sFillData;
    logic [3:0] sMissCount;
    int vectors = 0;
    int fails = 0;
    logic [31:0]  rdQ[$];
    logic [159:0] fillQ[$];
    logic [31:0]  invQ[$];
    logic [63:0]  wrQ[$];

    always #5 clk = ~clk;

    dcache_miss_controller dut (
        .clk(clk), .rst(rst), .cpu_read(cpuRead), .cpu_write(cpuWrite), .cpu_addr(cpuAddr),
        .cpu_wdata(cpuWdata), .cache_hit(cacheHit), .stall(stall), .mem_read_req(memReadReq),
        .mem_write_req(memWriteReq), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_ready(memReady), .mem_rdata(memRdata), .fill_en(fillEn), .fill_addr(fillAddr),
        .fill_data(fillData), .inv_en(invEn), .busy(busy), .miss_count(missCount)
    );

    dcache_miss_controller #(.CNT_W(4)) satDut (
        .clk(clk), .rst(rst), .cpu_read(cpuRead), .cpu_write(cpuWrite), .cpu_addr(cpuAddr),
        .cpu_wdata(cpuWdata), .cache_hit(cacheHit), .stall(sStall), .mem_read_req(sReadReq),
        .mem_write_req(sWriteReq), .mem_addr(sMemAddr), .mem_wdata(sMemWdata),
        .mem_ready(memReady), .mem_rdata(memRdata), .fill_en(sFillEn), .fill_addr(sFillAddr),
        .fill_data(sFillData), .inv_en(sInvEn), .busy(sBusy), .miss_count(sMissCount)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        vectors++;
        fails++;
        $display("FAIL %s: got a pulse, want none", nm);
    endtask

    // Monitor: every DUT-side event consumes the oldest expectation of its kind
    initial begin
        logic [159:0] f;
        logic [63:0] w;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (memReadReq && memWriteReq) unexpected("req_overlap");
                if (memReadReq && memReady) begin
                    if (rdQ.size() == 0) unexpected("rd_unexpected");
                    else begin a = rdQ.pop_front(); chk("rd_addr", 128'(memAddr), 128'(a)); end
                end
                if (memWriteReq && memReady) begin
                    if (wrQ.size() == 0) unexpected("wr_unexpected");
                    else begin
                        w = wrQ.pop_front();
                        chk("wr_addr", 128'(memAddr), 128'(w[63:32]));
                        chk("wr_data", 128'(memWdata), 128'(w[31:0]));
                    end
                end
                if (fillEn) begin
                    if (fillQ.size() == 0) unexpected("fill_unexpected");
                    else begin
                        f = fillQ.pop_front();
                        chk("fill_addr", 128'(fillAddr), 128'(f[159:128]));
                        chk("fill_data", fillData, f[127:0]);
                    end
                end
                if (invEn) begin
                    if (invQ.size() == 0) unexpected("inv_unexpected");
                    else begin a = invQ.pop_front(); chk("inv_addr", 128'(fillAddr), 128'(a)); end
                end
            end
        end
    end

    task automatic loadMiss(input logic [31:0] a, input int n, input logic [127:0] d,
                            input int expCnt);
        int st = 0, rq = 0;
        logic got = 1'b0;
        @(negedge clk);
        cpuRead = 1'b1; cpuWrite = 1'b0; cpuAddr = a; cacheHit = 1'b0; memReady = 1'b0;
        memRdata = d;
        rdQ.push_back({a[31:4], 4'h0});
        fillQ.push_back({a[31:4], 4'h0, d});
        for (int i = 0; i < 40; i++) begin
            #2;
            if (!stall) break;
            st++;
            if (fillEn) got = 1'b1;
            @(negedge clk);
            cacheHit = got;
            if (memReadReq) rq++;
            memReady = memReadReq && rq == n;
        end
        chk("load_stall_cycles", 128'(st), 128'(n + 2));
        chk("load_req_cycles", 128'(rq), 128'(n));
        chk("load_miss_count", 128'(missCount), 128'(expCnt));
        cpuRead = 1'b0;
    endtask

    task automatic storeOp(input logic [31:0] a, input logic [31:0] d, input logic hit,
                           input int n);
        int st = 0, rq = 0;
        @(negedge clk);
        cpuWrite = 1'b1; cpuRead = 1'b0; cpuAddr = a; cpuWdata = d; cacheHit = hit;
        memReady = 1'b0;
        wrQ.push_back({a, d});
        if (hit) invQ.push_back({a[31:4], 4'h0});
        for (int i = 0; i < 40; i++) begin
            #2;
            if (!stall) break;
            st++;
            @(negedge clk);
            if (memWriteReq) rq++;
            memReady = memWriteReq && rq == n;
        end
        chk("store_stall_cycles", 128'(st), 128'(n + 1));
        chk("store_req_cycles", 128'(rq), 128'(n));
        chk("wr_done_busy", 128'(busy), 128'(1));
        chk("wr_done_inv", 128'(invEn), 128'(hit));
        @(negedge clk);
        cpuWrite = 1'b0;
        #2;
        chk("after_store_busy", 128'(busy), 128'(0));
        chk("after_store_stall", 128'(stall), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        #2;
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_reqs", 128'({memReadReq, memWriteReq, fillEn, invEn}), 128'(0));
        chk("rst_addrs", 128'({memAddr, memWdata, fillAddr}), 128'(0));
        chk("rst_fill_data", fillData, 128'(0));
        chk("rst_miss_count", 128'(missCount), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        // Load hit, with a stray mem_ready that IDLE must ignore
        @(negedge clk);
        cpuRead = 1'b1; cpuAddr = 32'h40; cacheHit = 1'b1; memReady = 1'b1;
        #2;
        chk("hit_stall", 128'(stall), 128'(0));
        @(negedge clk);
        #2;
        chk("hit_busy", 128'(busy), 128'(0));
        chk("hit_no_req", 128'(memReadReq), 128'(0));
        chk("hit_miss_count", 128'(missCount), 128'(0));
        cpuRead = 1'b0; memReady = 1'b0;
        loadMiss(32'h1234, 3, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AA01, 1);
        storeOp(32'h88, 32'hDEADBEEF, 1'b1, 2);
        storeOp(32'h88, 32'hDEADBEEF, 1'b0, 2);
        loadMiss(32'h2008, 1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2);
        storeOp(32'h2004, 32'h1234_5678, 1'b1, 1);
        // Reset while a line fetch is pending
        @(negedge clk);
        cpuRead = 1'b1; cpuAddr = 32'h3000; cacheHit = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("pre_rst_req", 128'(memReadReq), 128'(1));
        rst = 1'b1; cpuRead = 1'b0;
        #1;
        chk("async_rst_req", 128'(memReadReq), 128'(0));
        chk("async_rst_stall", 128'(stall), 128'(0));
        chk("async_rst_busy", 128'(busy), 128'(0));
        chk("async_rst_count", 128'(missCount), 128'(0));
        memReady = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("post_rst_idle", 128'({busy, fillEn, invEn, memReadReq}), 128'(0));
        end
        memReady = 1'b0;
        // The 4-bit instance saturates after 15 misses; the 16-bit one keeps counting
        for (int i = 0; i < 16; i++)
            loadMiss(32'h100 * i + 32'h10, 1, 128'(i), i + 1);
        chk("sat_count_16", 128'(sMissCount), 128'(15));
        loadMiss(32'h5000, 1, 128'h55, 17);
        chk("sat_count_17", 128'(sMissCount), 128'(15));
        repeat (2) @(negedge clk);
        chk("queues_drained", 128'(rdQ.size() + wrQ.size() + fillQ.size() + invQ.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
